// File: rtl/gioco_pkg.sv
// ----------------------------------------------------------------------------
// gioco_pkg
// Shared definitions for the game controller and the game datapath.
//
// Contents:
//   stato_t         controller state encoding (SETUP, GIOCO, FINE_ST)
//   ESITO_*         two-bit result codes used on PARTITA, MANCHE and
//                   PARTITA_FINALE: none, player 1, player 2, draw
//   esito_valido()  true when a result code names an actual outcome
// ----------------------------------------------------------------------------
package gioco_pkg;

    typedef enum logic [1:0] {
        SETUP   = 2'b00,
        GIOCO   = 2'b01,
        FINE_ST = 2'b10
    } stato_t;

    localparam logic [1:0] ESITO_NESSUNO  = 2'b00;
    localparam logic [1:0] ESITO_P1       = 2'b01;
    localparam logic [1:0] ESITO_P2       = 2'b10;
    localparam logic [1:0] ESITO_PAREGGIO = 2'b11;

    // A round counts as played whenever the datapath reports any outcome,
    // draws included.
    function automatic logic esito_valido(input logic [1:0] esito);
        return (esito != ESITO_NESSUNO);
    endfunction

endpackage

// File: rtl/contatore_manche.sv
// ----------------------------------------------------------------------------
// contatore_manche
// Saturating round counter for the game controller.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   clr        in   1       synchronous clear (highest priority)
//   en         in   1       count one round on this edge
//   conteggio  out  CNT_W   rounds counted so far (registered)
//   terminale  out  1       high while conteggio == MAX_MANCHE-1, i.e. the
//                           next counted round is the last one allowed
// ----------------------------------------------------------------------------
module contatore_manche
    import gioco_pkg::*;
#(
    parameter int MAX_MANCHE = 19,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] conteggio,
    output logic             terminale
);

    localparam logic [CNT_W-1:0] VAL_MAX = CNT_W'(MAX_MANCHE);
    localparam logic [CNT_W-1:0] VAL_TC  = CNT_W'(MAX_MANCHE - 1);

    logic [CNT_W-1:0] conteggio_q;
    logic [CNT_W-1:0] conteggio_d;

    // Saturate at MAX_MANCHE so the count can never wrap, even if the
    // enable were held after the watchdog has fired.
    always_comb begin
        conteggio_d = conteggio_q;
        if (en && (conteggio_q != VAL_MAX)) begin
            conteggio_d = conteggio_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            conteggio_q <= '0;
        end else begin
            conteggio_q <= conteggio_d;
        end
    end

    assign conteggio = conteggio_q;
    assign terminale = (conteggio_q == VAL_TC);

endmodule

// File: rtl/controllore_partita.sv
// ----------------------------------------------------------------------------
// controllore_partita
// Control unit sitting directly upstream of the game datapath. It drives the
// datapath's setup/count strobes, latches the final result, counts rounds and
// forces a draw if the datapath never reports the end of the game.
//
// Ports:
//   clk             in   1      system clock, rising edge
//   INIZIO          in   1      synchronous active-high reset / start request
//   FINE_CONTO      in   1      datapath end-of-game flag
//   PARTITA         in   2      datapath game result
//   MANCHE          in   2      datapath round result (00 = no round)
//   INIZIO_SETUP    out  1      datapath: latch round-count configuration
//   INIZIO_CONTO    out  1      datapath: counting enabled, 0 clears counters
//   PARTITA_FINALE  out  2      latched final result
//   FINE            out  1      game over, PARTITA_FINALE valid
//   MANCHE_GIOCATE  out  CNT_W  rounds counted in this game
// ----------------------------------------------------------------------------
module controllore_partita
    import gioco_pkg::*;
#(
    parameter int MAX_MANCHE = 19,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             INIZIO,
    input  logic             FINE_CONTO,
    input  logic [1:0]       PARTITA,
    input  logic [1:0]       MANCHE,
    output logic             INIZIO_SETUP,
    output logic             INIZIO_CONTO,
    output logic [1:0]       PARTITA_FINALE,
    output logic             FINE,
    output logic [CNT_W-1:0] MANCHE_GIOCATE
);

    stato_t     stato_q;
    stato_t     stato_d;
    logic [1:0] partita_finale_q;
    logic [1:0] partita_finale_d;
    logic       fine_q;
    logic       fine_d;

    logic       manche_valida;
    logic       conta_en;
    logic       terminale;
    logic       watchdog;

    // Rounds are only counted while the game is live; in FINE_ST the datapath
    // is being cleared and anything on MANCHE is ignored.
    assign manche_valida = esito_valido(MANCHE);
    assign conta_en      = (stato_q == GIOCO) && manche_valida;

    contatore_manche #(
        .MAX_MANCHE (MAX_MANCHE),
        .CNT_W      (CNT_W)
    ) u_contatore (
        .clk       (clk),
        .clr       (INIZIO),
        .en        (conta_en),
        .conteggio (MANCHE_GIOCATE),
        .terminale (terminale)
    );

    // The watchdog fires on the edge that counts the last allowed round.
    // The counter itself increments on that edge, landing on MAX_MANCHE.
    assign watchdog = conta_en && terminale && !FINE_CONTO;

    // Next-state and result logic. FINE_CONTO takes precedence over the
    // watchdog so a genuine datapath result is never overwritten by the
    // forced draw. Unknown encodings fall back to SETUP.
    always_comb begin
        stato_d          = stato_q;
        partita_finale_d = partita_finale_q;
        fine_d           = fine_q;
        case (stato_q)
            SETUP: begin
                stato_d = GIOCO;
            end
            GIOCO: begin
                if (FINE_CONTO) begin
                    partita_finale_d = PARTITA;
                    fine_d           = 1'b1;
                    stato_d          = FINE_ST;
                end else if (watchdog) begin
                    partita_finale_d = ESITO_PAREGGIO;
                    fine_d           = 1'b1;
                    stato_d          = FINE_ST;
                end
            end
            FINE_ST: begin
                stato_d = FINE_ST;
            end
            default: begin
                stato_d          = SETUP;
                partita_finale_d = ESITO_NESSUNO;
                fine_d           = 1'b0;
            end
        endcase
    end

    // State and result registers; INIZIO restarts from any state.
    always_ff @(posedge clk) begin
        if (INIZIO) begin
            stato_q          <= SETUP;
            partita_finale_q <= ESITO_NESSUNO;
            fine_q           <= 1'b0;
        end else begin
            stato_q          <= stato_d;
            partita_finale_q <= partita_finale_d;
            fine_q           <= fine_d;
        end
    end

    // Moore strobes decoded straight from the state register; an illegal
    // encoding behaves like SETUP.
    always_comb begin
        INIZIO_SETUP = 1'b0;
        INIZIO_CONTO = 1'b0;
        case (stato_q)
            GIOCO:   INIZIO_CONTO = 1'b1;
            FINE_ST: ;
            default: INIZIO_SETUP = 1'b1;
        endcase
    end

    assign PARTITA_FINALE = partita_finale_q;
    assign FINE           = fine_q;

endmodule
